// File: rtl/mest_pro_pkg.sv
// Shared definitions for the program-run sequencer: sequencer states and
// default parameter values used by the top and its capture FIFO.
package mest_pro_pkg;

  localparam int DEF_RESULT_WIDTH   = 8;
  localparam int DEF_FIFO_DEPTH     = 16;
  localparam int DEF_NUM_RUNS       = 4;
  localparam int DEF_RESET_CYCLES   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int RUN_COUNT_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUT_RST,
    ST_START,
    ST_RUN,
    ST_NEXT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mest_pro_result_fifo.sv
// Sync capture FIFO; registered read, data 1 cycle after an accepted pop.
// No backpressure: a push while full without a same-cycle pop is dropped and flagged on drop.
module mest_pro_result_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full-FIFO push still lands.
  assign do_push = wr_vld && (!full || do_pop);
  assign drop    = wr_vld && !do_push;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rd_vld <= 1'b0;
      rd_dat <= '0;
    end else begin
      rd_vld <= do_pop;
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rd_dat <= mem[rptr];
        rptr   <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mest_pro_run_seq.sv
// Campaign sequencer: resets, starts and watches a DUT for NUM_RUNS runs, capturing results into a FIFO.
// Control outputs are registered from next state; host reads have 1-cycle latency, captures drop when full.
module mest_pro_run_seq
  import mest_pro_pkg::*;
#(
  parameter int RESULT_WIDTH   = DEF_RESULT_WIDTH,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int NUM_RUNS       = DEF_NUM_RUNS,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_timeout,
  output logic                    o_dut_reset_n,
  output logic                    o_memory_reset,
  output logic                    o_start,
  input  logic [RESULT_WIDTH-1:0] i_result,
  input  logic                    i_valid_result,
  input  logic                    i_carry,
  input  logic                    i_zero_flag,
  input  logic                    i_all_done,
  input  logic                    i_rd_en,
  output logic [RESULT_WIDTH+1:0] o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_fifo_empty,
  output logic                    o_fifo_full,
  output logic                    o_overflow,
  output logic [RUN_COUNT_W-1:0]  o_run_count
);

  localparam int RC_W = $clog2(RESET_CYCLES) + 1;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t                 state;
  state_t                 state_n;
  logic [RC_W-1:0]        rst_cnt;
  logic [WD_W-1:0]        wdog;
  logic                   wd_hit;
  logic [RUN_COUNT_W-1:0] run_count_inc;
  logic                   fifo_wr;
  logic                   fifo_drop;

  assign wd_hit        = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign run_count_inc = o_run_count + RUN_COUNT_W'(1);
  assign fifo_wr       = (state == ST_RUN) && i_valid_result;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (i_enable) state_n = ST_DUT_RST;
      ST_DUT_RST: if (rst_cnt == RC_W'(RESET_CYCLES - 1)) state_n = ST_START;
      ST_START:   state_n = ST_RUN;
      ST_RUN: begin
        if (i_all_done)  state_n = ST_NEXT;
        else if (wd_hit) state_n = ST_DONE;
      end
      ST_NEXT:    state_n = (run_count_inc == RUN_COUNT_W'(NUM_RUNS)) ? ST_DONE : ST_DUT_RST;
      ST_DONE:    if (!i_enable) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      rst_cnt        <= '0;
      wdog           <= '0;
      o_run_count    <= '0;
      o_timeout      <= 1'b0;
      o_overflow     <= 1'b0;
      o_dut_reset_n  <= 1'b0;
      o_memory_reset <= 1'b1;
      o_start        <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      state   <= state_n;
      rst_cnt <= (state == ST_DUT_RST) ? rst_cnt + RC_W'(1) : '0;
      // Held at zero outside RUN, so every RUN entry starts a fresh count.
      if (state != ST_RUN)  wdog <= '0;
      else if (wdog != '1)  wdog <= wdog + WD_W'(1);

      if (state == ST_IDLE && i_enable) begin
        o_run_count <= '0;
        o_timeout   <= 1'b0;
        o_overflow  <= 1'b0;
      end
      if (state == ST_NEXT)                        o_run_count <= run_count_inc;
      if (state == ST_RUN && !i_all_done && wd_hit) o_timeout  <= 1'b1;
      if (fifo_drop)                               o_overflow  <= 1'b1;

      o_dut_reset_n  <= (state_n != ST_DUT_RST);
      o_memory_reset <= (state_n == ST_DUT_RST);
      o_start        <= (state_n == ST_START);
      o_busy         <= (state_n == ST_DUT_RST) || (state_n == ST_START) ||
                        (state_n == ST_RUN) || (state_n == ST_NEXT);
      o_done         <= (state_n == ST_DONE);
    end
  end

  mest_pro_result_fifo #(
    .WIDTH (RESULT_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_reset (i_reset),
    .wr_vld  (fifo_wr),
    .wr_dat  ({i_carry, i_zero_flag, i_result}),
    .rd_en   (i_rd_en),
    .rd_vld  (o_rd_valid),
    .rd_dat  (o_rd_data),
    .empty   (o_fifo_empty),
    .full    (o_fifo_full),
    .drop    (fifo_drop)
  );

endmodule

// File: tb/tb_mest_pro_run_seq.sv
// Directed bench for mest_pro_run_seq with small parameters (depth 4, 2 runs, 16-cycle watchdog).
module tb_mest_pro_run_seq;

  localparam int RW = 8;
  localparam int DW = RW + 2;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_enable = 1'b0;
  logic          o_busy, o_done, o_timeout;
  logic          o_dut_reset_n, o_memory_reset, o_start;
  logic [RW-1:0] i_result = '0;
  logic          i_valid_result = 1'b0;
  logic          i_carry = 1'b0;
  logic          i_zero_flag = 1'b0;
  logic          i_all_done = 1'b0;
  logic          i_rd_en = 1'b0;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid, o_fifo_empty, o_fifo_full, o_overflow;
  logic [7:0]    o_run_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mest_pro_run_seq #(
    .RESULT_WIDTH   (RW),
    .FIFO_DEPTH     (4),
    .NUM_RUNS       (2),
    .RESET_CYCLES   (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_timeout      (o_timeout),
    .o_dut_reset_n  (o_dut_reset_n),
    .o_memory_reset (o_memory_reset),
    .o_start        (o_start),
    .i_result       (i_result),
    .i_valid_result (i_valid_result),
    .i_carry        (i_carry),
    .i_zero_flag    (i_zero_flag),
    .i_all_done     (i_all_done),
    .i_rd_en        (i_rd_en),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid),
    .o_fifo_empty   (o_fifo_empty),
    .o_fifo_full    (o_fifo_full),
    .o_overflow     (o_overflow),
    .o_run_count    (o_run_count)
  );

  typedef struct {
    logic          vld;
    logic [DW-1:0] dat;
    logic          pop;
    logic          e_full;
    logic          e_ovf;
    logic          e_empty;
    logic          e_rvld;
    logic [DW-1:0] e_rdat;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dut_reset_n"},  o_dut_reset_n,  0);
    check({tag, "_memory_reset"}, o_memory_reset, 1);
    check({tag, "_start"},        o_start,        0);
    check({tag, "_busy"},         o_busy,         0);
    check({tag, "_done"},         o_done,         0);
    check({tag, "_timeout"},      o_timeout,      0);
    check({tag, "_overflow"},     o_overflow,     0);
    check({tag, "_rd_valid"},     o_rd_valid,     0);
    check({tag, "_rd_data"},      o_rd_data,      0);
    check({tag, "_run_count"},    o_run_count,    0);
    check({tag, "_fifo_empty"},   o_fifo_empty,   1);
    check({tag, "_fifo_full"},    o_fifo_full,    0);
  endtask

  // Steps until o_start, counting DUT-reset cycles; ends one cycle later (first RUN cycle).
  task automatic wait_start(input string tag);
    int low = 0;
    int mres = 0;
    bit seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (o_start) begin
        seen = 1;
        break;
      end
      if (!o_dut_reset_n) low++;
      if (o_memory_reset) mres++;
    end
    check({tag, "_start_seen"}, seen, 1);
    check({tag, "_rst_low_cycles"}, low, 4);
    check({tag, "_memrst_cycles"}, mres, 4);
    step();
    check({tag, "_start_width"}, o_start, 0);
  endtask

  task automatic push(input logic c, input logic z, input logic [RW-1:0] r);
    i_valid_result = 1'b1;
    {i_carry, i_zero_flag, i_result} = {c, z, r};
    step();
    i_valid_result = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [DW-1:0] exp);
    i_rd_en = 1'b1;
    step();
    i_rd_en = 1'b0;
    check({name, "_vld"}, o_rd_valid, 1);
    check({name, "_dat"}, o_rd_data, exp);
  endtask

  initial begin
    int n;
    logic [DW-1:0] hold;

    tbl[0]  = '{1'b1, 10'h201, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0A6};
    tbl[1]  = '{1'b1, 10'h102, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0A6};
    tbl[2]  = '{1'b1, 10'h303, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0A6};
    tbl[3]  = '{1'b1, 10'h004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0A6};
    tbl[4]  = '{1'b1, 10'h005, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'h201};
    tbl[5]  = '{1'b1, 10'h006, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h201};
    tbl[6]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h102};
    tbl[7]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h102};
    tbl[8]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h303};
    tbl[9]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h004};
    tbl[10] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'h005};
    tbl[11] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h005};

    // Power-on reset
    step();
    step();
    check_reset_outputs("por");
    i_reset = 1'b0;
    step();
    check("idle_dut_reset_n", o_dut_reset_n, 1);
    check("idle_memory_reset", o_memory_reset, 0);

    // Campaign of two runs; stray valid in IDLE/DUT_RST/START must not be captured
    i_valid_result = 1'b1;
    {i_carry, i_zero_flag, i_result} = {1'b1, 1'b1, 8'hEE};
    i_enable = 1'b1;
    wait_start("run1");
    i_valid_result = 1'b0;
    check("run1_junk_ignored", o_fifo_empty, 1);
    check("run1_busy", o_busy, 1);
    push(1'b0, 1'b0, 8'h11);
    push(1'b1, 1'b0, 8'h22);
    push(1'b0, 1'b1, 8'h00);
    pop_expect("run1_pop0", 10'h011);
    pop_expect("run1_pop1", 10'h222);
    pop_expect("run1_pop2", 10'h100);
    i_all_done = 1'b1;
    step();
    i_all_done = 1'b0;
    wait_start("run2");
    check("run2_run_count", o_run_count, 1);
    push(1'b1, 1'b1, 8'h44);
    push(1'b0, 1'b0, 8'h55);
    i_all_done = 1'b1;
    push(1'b0, 1'b0, 8'hA6);
    i_all_done = 1'b0;
    check("run2_next_busy", o_busy, 1);
    step();
    check("camp_done", o_done, 1);
    check("camp_busy", o_busy, 0);
    check("camp_run_count", o_run_count, 2);
    check("camp_timeout", o_timeout, 0);
    pop_expect("run2_pop0", 10'h344);
    pop_expect("run2_pop1", 10'h055);
    pop_expect("run2_pop2", 10'h0A6);
    check("camp_empty", o_fifo_empty, 1);
    i_rd_en = 1'b1;
    step();
    i_rd_en = 1'b0;
    check("empty_pop_vld", o_rd_valid, 0);
    check("empty_pop_dat", o_rd_data, 10'h0A6);
    i_enable = 1'b0;
    step();
    check("back_idle_done", o_done, 0);
    check("back_idle_dut_reset_n", o_dut_reset_n, 1);

    // Watchdog: all_done never comes
    i_enable = 1'b1;
    wait_start("to");
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (o_timeout) break;
    end
    check("to_cycles", n, 16);
    check("to_flag", o_timeout, 1);
    check("to_done", o_done, 1);
    check("to_busy", o_busy, 0);
    check("to_run_count", o_run_count, 0);
    i_enable = 1'b0;
    step();
    check("to_sticky", o_timeout, 1);

    // FIFO fill / overflow table inside a run
    i_enable = 1'b1;
    wait_start("fifo");
    check("fifo_timeout_cleared", o_timeout, 0);
    for (int i = 0; i < 12; i++) begin
      i_valid_result = tbl[i].vld;
      {i_carry, i_zero_flag, i_result} = tbl[i].dat;
      i_rd_en = tbl[i].pop;
      step();
      check($sformatf("tbl%0d_full", i),  o_fifo_full,  tbl[i].e_full);
      check($sformatf("tbl%0d_ovf", i),   o_overflow,   tbl[i].e_ovf);
      check($sformatf("tbl%0d_empty", i), o_fifo_empty, tbl[i].e_empty);
      check($sformatf("tbl%0d_rvld", i),  o_rd_valid,   tbl[i].e_rvld);
      check($sformatf("tbl%0d_rdat", i),  o_rd_data,    tbl[i].e_rdat);
    end
    i_valid_result = 1'b0;
    i_rd_en = 1'b0;
    hold = o_rd_data;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_done) break;
      step();
      n++;
    end
    check("fifo_run_ends", o_done, 1);
    check("fifo_rd_data_stable", o_rd_data, hold);
    i_enable = 1'b0;
    step();

    // Reset asserted mid-run
    i_enable = 1'b1;
    wait_start("abort");
    push(1'b1, 1'b0, 8'h77);
    push(1'b0, 1'b1, 8'h88);
    check("abort_pre_empty", o_fifo_empty, 0);
    i_rd_en = 1'b1;
    i_reset = 1'b1;
    step();
    i_rd_en = 1'b0;
    check_reset_outputs("abort");
    i_reset = 1'b0;
    i_enable = 1'b0;
    step();
    check("abort_idle_dut_reset_n", o_dut_reset_n, 1);
    check("abort_idle_start", o_start, 0);
    check("abort_idle_empty", o_fifo_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
